// File: rtl/sar_search4b.sv
// 4-bit successive-approximation search against an external comparator.
// Binary-searches a secret over at most four compares, with early exit on equality and abort.
module sar_search4b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cmp_gt,
  input  logic       cmp_eq,
  output logic [3:0] trial,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic [2:0] ncmp,
  output logic       early
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [2:0] cnt_q, cnt_d;
  logic [3:0] trial_q, trial_d;
  logic [3:0] result_q, result_d;
  logic [2:0] ncmp_q, ncmp_d;
  logic       early_q, early_d;
  logic [3:0] trial_upd;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    cnt_d     = cnt_q;
    trial_d   = trial_q;
    result_d  = result_q;
    ncmp_d    = ncmp_q;
    early_d   = early_q;
    // Resolve the current bit from the comparator: keep it if the secret is above the trial.
    trial_upd = trial_q;
    trial_upd[k_q] = cmp_gt;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSearch;
          k_d     = 2'd3;
          cnt_d   = 3'd0;
          trial_d = 4'b1000;
        end
      end
      StSearch: begin
        cnt_d = cnt_q + 3'd1;
        if (abort) begin
          state_d = StIdle;
          trial_d = 4'b0000;
        end else if (cmp_eq) begin
          result_d = trial_q;
          ncmp_d   = cnt_q + 3'd1;
          early_d  = 1'b1;
          state_d  = StDone;
          trial_d  = 4'b0000;
        end else if (k_q != 2'd0) begin
          k_d     = k_q - 2'd1;
          trial_d = trial_upd;
          trial_d[k_q - 2'd1] = 1'b1;
        end else begin
          result_d = trial_upd;
          ncmp_d   = 3'd4;
          early_d  = 1'b0;
          state_d  = StDone;
          trial_d  = 4'b0000;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        trial_d = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      k_q      <= 2'd3;
      cnt_q    <= 3'd0;
      trial_q  <= 4'b0000;
      result_q <= 4'b0000;
      ncmp_q   <= 3'd0;
      early_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      ncmp_q   <= ncmp_d;
      early_q  <= early_d;
    end
  end

  assign trial  = trial_q;
  assign busy   = (state_q == StSearch);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign ncmp   = ncmp_q;
  assign early  = early_q;

endmodule

// File: tb/tb_sar_search4b.sv
// Bench for sar_search4b: behavioural comparator, directed vector table, abort/reset/flag
// corner sequences and a full secret sweep.
module tb_sar_search4b;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       cmp_gt, cmp_eq;
  logic [3:0] trial, result;
  logic       busy, done, early;
  logic [2:0] ncmp;

  logic [3:0] secret;
  logic       ovr, ovr_gt, ovr_eq;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign cmp_gt = ovr ? ovr_gt : (secret > trial);
  assign cmp_eq = ovr ? ovr_eq : (secret == trial);

  sar_search4b dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .abort  (abort),
    .cmp_gt (cmp_gt),
    .cmp_eq (cmp_eq),
    .trial  (trial),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ncmp   (ncmp),
    .early  (early)
  );

  typedef struct {
    logic [3:0] sec;
    logic [3:0] res;
    logic [2:0] n;
    logic       e;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Compares expected for a well-behaved comparator: stop at the lowest set bit.
  function automatic int exp_ncmp(input logic [3:0] s);
    if (s == 4'd0) return 4;
    for (int p = 0; p < 4; p++) if (s[p]) return 4 - p;
    return 4;
  endfunction

  // Runs one search from IDLE; latency counts edges from the start-sampling edge inclusive.
  task automatic run_search(input logic [3:0] sec, input logic [3:0] er, input int en,
                            input int ee, input string tag);
    int lat = 0;
    secret = sec;
    start  = 1'b1;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) lat = i;
      else if (i == 1) begin
        check({tag, " first_trial"}, int'(trial), 8);
        check({tag, " busy_search"}, int'(busy), 1);
      end
    end
    check({tag, " latency"}, lat, en + 1);
    check({tag, " result"}, int'(result), int'(er));
    check({tag, " ncmp"}, int'(ncmp), en);
    check({tag, " early"}, int'(early), ee);
    check({tag, " busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, int'(done), 0);
    check({tag, " idle_trial"}, int'(trial), 0);
  endtask

  initial begin
    vecs[0] = '{sec: 4'd8,  res: 4'd8,  n: 3'd1, e: 1'b1};
    vecs[1] = '{sec: 4'd0,  res: 4'd0,  n: 3'd4, e: 1'b0};
    vecs[2] = '{sec: 4'd6,  res: 4'd6,  n: 3'd3, e: 1'b1};
    vecs[3] = '{sec: 4'd15, res: 4'd15, n: 3'd4, e: 1'b1};
    vecs[4] = '{sec: 4'd1,  res: 4'd1,  n: 3'd4, e: 1'b1};
    vecs[5] = '{sec: 4'd12, res: 4'd12, n: 3'd2, e: 1'b1};
    vecs[6] = '{sec: 4'd10, res: 4'd10, n: 3'd3, e: 1'b1};
    vecs[7] = '{sec: 4'd7,  res: 4'd7,  n: 3'd4, e: 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    secret = 4'd0; ovr = 1'b0; ovr_gt = 1'b0; ovr_eq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst trial", int'(trial), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst result", int'(result), 0);
    check("rst ncmp", int'(ncmp), 0);
    check("rst early", int'(early), 0);

    // Start sampled on the first edge after reset release.
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++)
      run_search(vecs[i].sec, vecs[i].res, int'(vecs[i].n), int'(vecs[i].e), "vec");

    // Abort on the 2nd SEARCH cycle with start held high; prior results must survive.
    run_search(4'd6, 4'd6, 3, 1, "pre_abort");
    secret = 4'd5;
    start  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort no_restart trial", int'(trial), 4);
    check("abort busy_before", int'(busy), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort trial", int'(trial), 0);
    check("abort result", int'(result), 6);
    check("abort ncmp", int'(ncmp), 3);
    check("abort early", int'(early), 1);
    @(posedge clk); #1;
    check("abort no_done_later", int'(done), 0);

    // Abort in IDLE is ignored: the start still launches a search.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("abort_idle busy", int'(busy), 1);
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_idle cancelled", int'(busy), 0);

    // Reset on the 3rd SEARCH cycle, then a clean search right after release.
    secret = 4'd15;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", int'(busy), 0);
    check("midrst done", int'(done), 0);
    check("midrst trial", int'(trial), 0);
    check("midrst result", int'(result), 0);
    check("midrst ncmp", int'(ncmp), 0);
    check("midrst early", int'(early), 0);
    rst_n = 1'b1;
    run_search(4'd15, 4'd15, 4, 1, "post_rst");

    // Both flags high: equality wins on the first compare.
    ovr = 1'b1; ovr_gt = 1'b1; ovr_eq = 1'b1;
    run_search(4'd0, 4'd8, 1, 1, "both_flags");
    // Contradictory always-greater comparator still ends after four compares.
    ovr_eq = 1'b0;
    run_search(4'd0, 4'd15, 4, 0, "always_gt");
    ovr = 1'b0;

    for (int s = 0; s < 16; s++)
      run_search(4'(s), 4'(s), exp_ncmp(4'(s)), (s != 0) ? 1 : 0, "sweep");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sar_search4b.md
SAR_SEARCH4B -- requirements
Module: sar_search4b

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 The ports SHALL be, in this order:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request a new search; sampled in IDLE only
- abort  input  1  cancel a search in progress
- cmp_gt  input  1  external 4-bit comparator flag: secret > trial, combinational from trial
- cmp_eq  input  1  external 4-bit comparator flag: secret == trial, combinational from trial
- trial  output  4  registered trial operand driven to the comparator
- busy  output  1  high while in SEARCH
- done  output  1  one-cycle completion pulse
- result  output  4  recovered secret from the last completed search
- ncmp  output  3  number of compare cycles used by the last completed search (1..4)
- early  output  1  last completed search ended on cmp_eq

Function
REQ-003 The FSM SHALL have three states, IDLE, SEARCH and DONE, plus a 2-bit bit index k.
REQ-004 In IDLE with start=1, the next state SHALL be SEARCH with k=3, trial=4'b1000 and the internal compare counter set to 0.
REQ-005 In IDLE, trial SHALL be 4'b0000 and busy=0.
REQ-006 Each SEARCH cycle SHALL be one compare: cmp_gt and cmp_eq are sampled against the current trial, and the internal counter increments by 1.
REQ-007 In SEARCH with cmp_eq=1 and abort=0, the block SHALL:
- load result=trial, ncmp=counter+1 and early=1;
- move to DONE.
REQ-008 In SEARCH with cmp_eq=0, the block SHALL keep bit k of trial if cmp_gt=1 and clear it if cmp_gt=0.
REQ-009 After REQ-008, if k>0 the block SHALL decrement k and set the new bit k of trial.
REQ-010 After REQ-008, if k=0 the block SHALL:
- load result with the updated trial, ncmp=4 and early=0;
- move to DONE.
REQ-011 In DONE, done SHALL be 1 and busy SHALL be 0, for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-012 done SHALL be 0 in every state other than DONE.
REQ-013 start SHALL be ignored in SEARCH and DONE; no request is queued.
REQ-014 abort=1 in SEARCH SHALL force IDLE on the next edge, override any simultaneous cmp_eq or k=0 completion, leave result/ncmp/early unchanged, and never assert done.
REQ-015 abort SHALL be ignored in IDLE and DONE.
REQ-016 result, ncmp and early SHALL change only on completion (REQ-007, REQ-010) and SHALL hold their values otherwise.
REQ-017 Latency from the start-sampling edge to done=1 SHALL be ncmp+1 cycles (minimum 2, maximum 5).
REQ-018 If cmp_gt and cmp_eq are both 1, cmp_eq SHALL take priority.
REQ-019 Contradictory flag sequences SHALL still terminate within 4 compares with a defined 4-bit result.

Reset
REQ-020 With rst_n=0 at a clock edge, the block SHALL set:
- state=IDLE, k=3, internal counter=0;
- trial=0, busy=0, done=0;
- result=0, ncmp=0, early=0.
REQ-021 Reset asserted mid-SEARCH or in DONE SHALL abandon the search with no done pulse.
REQ-022 start sampled on the first edge after rst_n rises SHALL be honoured.

Verification
REQ-023 secret=8, start pulse -> trial 1000, eq -> done after 2 cycles; result=8, ncmp=1, early=1.
REQ-024 secret=0 -> trials 1000, 0100, 0010, 0001 all lt -> result=0, ncmp=4, early=0, done 5 cycles after start.
REQ-025 secret=6 -> trials 1000 (lt), 0100 (gt), 0110 (eq) -> result=6, ncmp=3, early=1.
REQ-026 secret=5, abort on the 2nd SEARCH cycle -> IDLE next edge, no done, result/ncmp/early retain the prior search values; start held high during SEARCH causes no restart.
REQ-027 rst_n=0 on the 3rd SEARCH cycle (secret=15) -> next edge all outputs 0 and IDLE; a new search then returns result=15, ncmp=4, early=1.
REQ-028 Exhaustive sweep, secret 0..15, back-to-back starts -> result==secret for every value; done is exactly one cycle per search; busy=0 whenever done=1.
